alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU.
- Width-generic.
- Keeps the existing 4-bit operation codes and adds shifts, unsigned compare and an iterative multiply.
- Produces a full flag set and flags illegal opcodes.
- Sits between the decode/operand-read stage and writeback. Valid/ready on both sides lets a multi-cycle op stall upstream cleanly.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_pipe.sv | 137 +++++++++++++
 tb/tb_alu_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_NOR  = 4'b1100
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic illegal_op;
    } flags_t;

    function automatic flags_t mk_flags(
        input logic is_zero,
        input logic msb,
        input logic c,
        input logic v,
        input logic ill
    );
        flags_t f;
        f.zero       = is_zero;
        f.negative   = msb;
        f.carry      = c;
        f.overflow   = v;
        f.illegal_op = ill;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Sequential shift-add multiplier: one multiplier bit per cycle after start.
import alu_pkg::*;

module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    // product is valid combinationally during the final step
    assign done     = busy && (count == CW'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between operand read and writeback; MUL iterates WIDTH cycles.
import alu_pkg::*;

module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] read2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    state_t           state;
    flags_t           flags_q;
    flags_t           alu_flags;
    op_t              op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic             c;
    logic             v;
    logic             ill;
    logic             in_fire;
    logic             out_fire;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op        = op_t'(operation);
    assign shamt     = read2[SHW-1:0];
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign mul_start = in_fire && (op == OP_MUL);

    always_comb begin
        sum     = {1'b0, read1} + {1'b0, read2};
        diff    = {1'b0, read1} - {1'b0, read2};
        alu_res = '0;
        c       = 1'b0;
        v       = 1'b0;
        ill     = 1'b0;
        unique case (op)
            OP_AND:  alu_res = read1 & read2;
            OP_OR:   alu_res = read1 | read2;
            OP_NOR:  alu_res = ~(read1 | read2);
            OP_ADD: begin
                alu_res = sum[M:0];
                c       = sum[WIDTH];
                v       = (read1[M] == read2[M]) && (sum[M] != read1[M]);
            end
            OP_SUB: begin
                alu_res = diff[M:0];
                c       = diff[WIDTH];
                v       = (read1[M] != read2[M]) && (diff[M] != read1[M]);
            end
            OP_SLT:  alu_res = {{M{1'b0}}, $signed(read1) < $signed(read2)};
            OP_SLTU: alu_res = {{M{1'b0}}, read1 < read2};
            OP_SLL:  alu_res = read1 << shamt;
            OP_SRL:  alu_res = read1 >> shamt;
            OP_SRA:  alu_res = $signed(read1) >>> shamt;
            // MUL result comes from the iterative unit, never from here
            OP_MUL:  alu_res = '0;
            default: ill = 1'b1;
        endcase
        alu_flags = mk_flags(alu_res == '0, alu_res[M], c, v, ill);
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (read1),
        .b      (read2),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire && op != OP_MUL) begin
                        result    <= alu_res;
                        flags_q   <= alu_flags;
                        out_valid <= 1'b1;
                    end else if (in_fire) begin
                        state     <= MUL;
                        out_valid <= 1'b0;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        flags_q   <= mk_flags(mul_product == '0,
                                              mul_product[M],
                                              1'b0, 1'b0, 1'b0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign zero       = flags_q.zero;
    assign negative   = flags_q.negative;
    assign carry      = flags_q.carry;
    assign overflow   = flags_q.overflow;
    assign illegal_op = flags_q.illegal_op;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  operation = 4'h0;
    logic [31:0] read1 = '0;
    logic [31:0] read2 = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, negative, carry, overflow, illegal_op;

    int n_total = 0;
    int n_pass  = 0;
    int ready_mode = 0;
    logic [36:0] q[$];

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .read1(read1), .read2(read2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] pack_dut();
        return {result, zero, negative, carry, overflow, illegal_op};
    endfunction

    // Reference: plain 64-bit arithmetic, overflow = truncation changes value
    function automatic logic [36:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        longint unsigned u;
        logic [31:0] r = '0;
        logic cf = 1'b0, vf = 1'b0, il = 1'b0;
        int amt = int'(b[4:0]);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd2: begin
                u = ua + ub; r = u[31:0]; cf = u[32];
                s = sa + sb; vf = (s != longint'($signed(r)));
            end
            4'd6: begin
                r = a - b; cf = (ua < ub);
                s = sa - sb; vf = (s != longint'($signed(r)));
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd3: begin u = ua << amt; r = u[31:0]; end
            4'd4: begin u = ua >> amt; r = u[31:0]; end
            4'd5: begin s = sa >>> amt; r = s[31:0]; end
            4'd8: begin u = ua * ub; r = u[31:0]; end
            default: il = 1'b1;
        endcase
        return {r, (r == 32'h0), r[31], cf, vf, il};
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int w = 0;
        operation = op; read1 = a; read2 = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: every valid output must equal the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else chk("model", {27'h0, pack_dut()}, {27'h0, q[0]});
                if (out_ready && q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back(model(operation, read1, read2));
        end
    end

    initial begin
        int busy;
        int seen;

        chk("pin_add", {27'h0, model(4'd2, 32'h7FFF_FFFF, 32'h1)},
            {27'h0, 32'h8000_0000, 5'b01010});
        chk("pin_sub", {27'h0, model(4'd6, 32'd5, 32'd7)},
            {27'h0, 32'hFFFF_FFFE, 5'b01100});
        chk("pin_sra", {27'h0, model(4'd5, 32'h8000_0000, 32'h21)},
            {27'h0, 32'hC000_0000, 5'b01000});
        chk("pin_mul", {27'h0, model(4'd8, 32'hFFFF, 32'h10001)},
            {27'h0, 32'hFFFF_FFFF, 5'b01000});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_state", {26'h0, out_valid, in_ready, pack_dut()},
            {26'h0, 1'b0, 1'b1, 37'h0});
        @(posedge clk); #1;

        send(4'd2, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovf", {27'h0, pack_dut()}, {27'h0, 32'h8000_0000, 5'b01010});
        chk("add_valid", {63'h0, out_valid}, 64'd1);

        send(4'd6, 32'd5, 32'd7);
        chk("sub_res", {27'h0, pack_dut()}, {27'h0, 32'hFFFF_FFFE, 5'b01100});
        chk("sub_ready", {63'h0, in_ready}, 64'd1);
        send(4'd9, 32'd5, 32'd7);
        chk("sltu_res", {27'h0, pack_dut()}, {27'h0, 32'h1, 5'b00000});
        chk("sltu_ready", {63'h0, in_ready}, 64'd1);

        send(4'd8, 32'hFFFF, 32'h10001);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) busy++;
        end
        chk("mul_busy", 64'(busy), 64'd32);
        chk("mul_res", {26'h0, out_valid, pack_dut()},
            {26'h0, 1'b1, 32'hFFFF_FFFF, 5'b01000});
        @(posedge clk); #1;

        send(4'd8, 32'hFFFF, 32'h10001);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_noout", 64'(seen), 64'd0);
        chk("abort_idle", {26'h0, in_ready, result, 5'h0},
            {26'h0, 1'b1, 32'h0, 5'h0});
        @(posedge clk); #1;

        send(4'd5, 32'h8000_0000, 32'h21);
        chk("sra_res", {32'h0, result}, 64'hC000_0000);
        send(4'd3, 32'h1234_5678, 32'h20);
        chk("sll0_res", {32'h0, result}, 64'h1234_5678);
        @(posedge clk); #1;

        ready_mode = 1;
        @(posedge clk); #3;
        send(4'hF, 32'hDEAD_BEEF, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ill_hold", {26'h0, out_valid, in_ready, pack_dut()},
                {26'h0, 1'b1, 1'b0, 32'h0, 5'b10001});
        end
        ready_mode = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("drain_clear", {63'h0, out_valid}, 64'd0);

        ready_mode = 2;
        for (int t = 0; t < 300; t++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            send(op, pick(), pick());
        end
        ready_mode = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
